// File: rtl/irq_ctrl_pkg.sv
// Shared register map, FSM state encoding and claim-word helper for irq_ctrl.
package irq_ctrl_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CLAIM_VALID_BIT = 31;
    localparam int ID_W            = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        IN_SERVICE = 2'd2
    } state_t;

    function automatic logic [31:0] claim_word(input logic [ID_W-1:0] id);
        logic [31:0] w;
        w = 32'(id);
        w[CLAIM_VALID_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/irq_src_edge.sv
// Per-source rising-edge detector; IRQ_CTRL_SYNC_EN inserts a two-flop synchronizer
// ahead of the edge capture.
module irq_src_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_s;
    logic prev;

`ifdef IRQ_CTRL_SYNC_EN
    logic sync_a;
    logic sync_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= level;
            sync_b <= sync_a;
        end
    end

    assign level_s = sync_b;
`else
    assign level_s = level;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= level_s;
    end

    assign pulse = level_s & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Edge-capturing interrupt controller with claim/complete handshake over a simple bus.
// Optional input synchronizers are enabled with the IRQ_CTRL_SYNC_EN macro.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic               ack_o,
    output logic [31:0]        rdata_o,
    output logic               irq_o
);

    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [NUM_SRC-1:0] claim_clr;
    logic [ID_W-1:0]    claim_id;
    logic [ID_W-1:0]    claimed_id;
    state_t             state;
    logic               bus_rd;
    logic               bus_wr;
    logic               claim_hit;
    logic               complete_hit;
    logic               unused_wdata;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_src_edge u_edge (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .level (src_i[i]),
            .pulse (edges[i])
        );
    end

    assign active       = pending & enable;
    assign bus_rd       = req_i & ~we_i;
    assign bus_wr       = req_i & we_i;
    assign claim_hit    = bus_rd && (addr_i == REG_CLAIM) && (state == ASSERT) && (|active);
    assign complete_hit = bus_wr && (addr_i == REG_CLAIM) && (state == IN_SERVICE)
                          && (wdata_i[ID_W-1:0] == claimed_id);
    assign w1c_clr      = (bus_wr && addr_i == REG_PENDING) ? wdata_i[NUM_SRC-1:0] : '0;
    assign claim_clr    = claim_hit ? (NUM_SRC'(1) << claim_id) : '0;
    assign unused_wdata = ^wdata_i;

    // Lowest index wins: scan downward so the last hit is the smallest id.
    always_comb begin
        claim_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) claim_id = ID_W'(i);
        end
    end

    // A fresh edge outranks any clear landing on the same bit in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending <= '0;
            enable  <= '0;
        end else begin
            pending <= (pending & ~w1c_clr & ~claim_clr) | edges;
            if (bus_wr && addr_i == REG_ENABLE) enable <= wdata_i[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ack_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            ack_o   <= req_i;
            rdata_o <= '0;
            if (bus_rd) begin
                case (addr_i)
                    REG_PENDING: rdata_o <= 32'(pending);
                    REG_ENABLE:  rdata_o <= 32'(enable);
                    REG_CLAIM:   rdata_o <= claim_hit ? claim_word(claim_id) : 32'd0;
                    default:     rdata_o <= {22'd0, state, 3'd0, claimed_id};
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            irq_o      <= 1'b0;
            claimed_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|active) begin
                        state <= ASSERT;
                        irq_o <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (claim_hit) begin
                        state      <= IN_SERVICE;
                        irq_o      <= 1'b0;
                        claimed_id <= claim_id;
                    end else if (!(|active)) begin
                        state <= IDLE;
                        irq_o <= 1'b0;
                    end
                end
                IN_SERVICE: begin
                    if (complete_hit) state <= IDLE;
                    irq_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    irq_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed test of irq_ctrl: edge capture, claim/complete, priority, W1C races and reset.
module tb_irq_ctrl;

    localparam logic [1:0] A_PEND   = 2'd0;
    localparam logic [1:0] A_ENABLE = 2'd1;
    localparam logic [1:0] A_CLAIM  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  src;
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] rd;

    irq_ctrl #(.NUM_SRC(4)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .src_i   (src),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ack_o   (ack),
        .rdata_o (rdata),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        step();
        req = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        step();
        req = 1'b0;
        d = rdata;
        chk("read_ack", 32'(ack), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; src = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        step(); step(); step();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        step();
        bus_read(A_PEND, rd);    chk("rst_pending", rd, 32'h0);
        bus_read(A_ENABLE, rd);  chk("rst_enable", rd, 32'h0);
        bus_read(A_STATUS, rd);  chk("rst_status", rd, 32'h0);
        step();
        chk("ack_one_cycle", 32'(ack), 32'd0);
        chk("rdata_idle_zero", rdata, 32'd0);

        // Timer source: edge capture, irq latency and no re-trigger while held.
        bus_write(A_ENABLE, 32'h1);
        src = 4'b0001;
        step();
        chk("t1_irq_after_1", 32'(irq), 32'd0);
        step();
        chk("t1_irq_after_2", 32'(irq), 32'd1);
        bus_read(A_PEND, rd);    chk("t1_pending", rd, 32'h1);
        bus_read(A_CLAIM, rd);   chk("t1_claim", rd, 32'h8000_0000);
        chk("t1_irq_low_claim", 32'(irq), 32'd0);
        step(); step();
        bus_read(A_PEND, rd);    chk("t1_no_retrigger", rd, 32'h0);
        bus_write(A_CLAIM, 32'h0);
        step();
        chk("t1_irq_idle", 32'(irq), 32'd0);
        bus_read(A_STATUS, rd);  chk("t1_status_idle", rd, 32'h0);
        src = 4'b0000;

        // Simultaneous sources: priority, mismatched and matching complete.
        bus_write(A_ENABLE, 32'hF);
        src = 4'b1010;
        step();
        src = 4'b0000;
        step();
        chk("t2_irq", 32'(irq), 32'd1);
        bus_read(A_CLAIM, rd);   chk("t2_claim1", rd, 32'h8000_0001);
        chk("t2_irq_low", 32'(irq), 32'd0);
        bus_read(A_PEND, rd);    chk("t2_pending", rd, 32'h8);
        bus_read(A_STATUS, rd);  chk("t2_status_svc", rd, 32'h201);
        bus_write(A_CLAIM, 32'h3);
        bus_read(A_STATUS, rd);  chk("t2_bad_complete", rd, 32'h201);
        chk("t2_irq_still_low", 32'(irq), 32'd0);
        bus_write(A_CLAIM, 32'h1);
        chk("t2_irq_at_idle", 32'(irq), 32'd0);
        step();
        chk("t2_irq_reassert", 32'(irq), 32'd1);
        bus_read(A_CLAIM, rd);   chk("t2_claim3", rd, 32'h8000_0003);
        bus_write(A_CLAIM, 32'h3);
        bus_read(A_PEND, rd);    chk("t2_pending_empty", rd, 32'h0);
        bus_read(A_STATUS, rd);  chk("t2_status_idle", rd, 32'h3);

        // Enable writes are masked to the configured source width.
        bus_write(A_ENABLE, 32'hFFFF_FFFF);
        bus_read(A_ENABLE, rd);  chk("enable_mask", rd, 32'hF);

        // Edge set beats a W1C clear in the same cycle.
        bus_write(A_ENABLE, 32'h0);
        src = 4'b0100;
        bus_write(A_PEND, 32'h4);
        bus_read(A_PEND, rd);    chk("t3_edge_wins", rd, 32'h4);
        bus_write(A_PEND, 32'h4);
        bus_read(A_PEND, rd);    chk("t3_w1c", rd, 32'h0);
        src = 4'b0000;

        // Masked pending: claim returns nothing and the FSM stays idle.
        src = 4'b0010;
        step();
        src = 4'b0000;
        bus_read(A_PEND, rd);    chk("t4_pending", rd, 32'h2);
        bus_read(A_CLAIM, rd);   chk("t4_claim_empty", rd, 32'h0);
        bus_read(A_STATUS, rd);  chk("t4_state_idle", rd & 32'h300, 32'h0);
        chk("t4_irq", 32'(irq), 32'd0);
        bus_write(A_PEND, 32'h2);

        // Reset in service with the timer line held high.
        bus_write(A_ENABLE, 32'h1);
        src = 4'b0001;
        step(); step();
        chk("t5_irq", 32'(irq), 32'd1);
        bus_read(A_CLAIM, rd);   chk("t5_claim", rd, 32'h8000_0000);
        bus_read(A_STATUS, rd);  chk("t5_status_svc", rd, 32'h200);
        rst_n = 1'b0;
        step(); step();
        chk("t5_irq_in_rst", 32'(irq), 32'd0);
        rst_n = 1'b1;
        step();
        bus_read(A_PEND, rd);    chk("t5_pending_after_rst", rd, 32'h1);
        bus_read(A_ENABLE, rd);  chk("t5_enable_after_rst", rd, 32'h0);
        bus_read(A_STATUS, rd);  chk("t5_status_after_rst", rd, 32'h0);
        chk("t5_irq_masked", 32'(irq), 32'd0);
        bus_write(A_ENABLE, 32'h1);
        chk("t5_irq_not_yet", 32'(irq), 32'd0);
        step();
        chk("t5_irq_enabled", 32'(irq), 32'd1);
        src = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller sitting directly downstream of the SoC timer and other peripheral interrupt sources; it captures rising edges of level interrupt lines into a pending register and masks them with an enable register. It drives a single interrupt request to the core and arbitrates with a claim/complete handshake over the SoC memory-mapped bus. Source 0 is hard-wired to the timer's interrupt output. The timer holds its line high until re-armed, so edge capture prevents re-triggering.

## Interface
- NUM_SRC, 4: number of interrupt sources, 1..32; bit 0 = timer.
- clk_i  input  1  system clock.
- rst_ni  input  1  synchronous, active-low reset.
- src_i  input  NUM_SRC  level interrupt lines; src_i[0] from timer irq output.
- req_i  input  1  bus request strobe, single cycle.
- we_i  input  1  1 = write, 0 = read; valid with req_i.
- addr_i  input  2  word register index; valid with req_i.
- wdata_i  input  32  write data; valid with req_i.
- ack_o  output  1  bus acknowledge, one cycle after req_i.
- rdata_o  output  32  read data, valid with ack_o, 0 otherwise.
- irq_o  output  1  interrupt request to core, registered.

## Operation
- Edge capture: prev[i] registered copy of src_i[i]; edge[i] = src_i[i] & ~prev[i]; edge sets pending[i].
- Registers (addr_i):
  - 0 PENDING: read pending; write-1-to-clear.
  - 1 ENABLE: read/write; bits >= NUM_SRC read 0, writes ignored.
  - 2 CLAIM: read = claim; write = complete (wdata_i[4:0] = id).
  - 3 STATUS: read {state[1:0] in [9:8], claimed id in [4:0]}; writes ignored.
- active = pending & enable.
- FSM states: IDLE, ASSERT, IN_SERVICE.
  - IDLE -> ASSERT when |active.
  - ASSERT -> IDLE when active becomes 0 (pending cleared or enable masked before claim).
  - ASSERT -> IN_SERVICE on CLAIM read.
  - IN_SERVICE -> IDLE on CLAIM write with wdata_i[4:0] == claimed id.
  - Mismatched complete is ignored.
- irq_o = 1 only in ASSERT.
- CLAIM read in ASSERT:
  - Returns {1'b1 in bit 31, lowest-index active id in [4:0]}.
  - Clears that pending bit.
  - Latches the id.
- CLAIM read in IDLE or IN_SERVICE: returns 0 (valid bit 0); no state change.
- Simultaneous events on the same bit and cycle: edge set wins over W1C clear and over claim clear.
- Reset values: pending, enable, prev, claimed id = 0; state IDLE; ack_o, rdata_o, irq_o = 0.
- Because prev resets to 0, a source held high through reset registers an edge on the first active cycle after reset.
- Reset asserted mid-service abandons the claim; no complete is required.

## Timing
- src_i rises, sampled at edge N: pending set after N+1, irq_o high after N+2.
- Bus: req_i sampled at edge N; ack_o and rdata_o valid for exactly one cycle after N+1.
- Register writes take effect at edge N.
- CLAIM read at edge N: irq_o low after N+1; state IN_SERVICE after N+1.
- Complete at edge N: state IDLE after N+1. If active is still nonzero, irq_o re-asserts after N+2.
- Back-to-back requests are accepted every cycle.

## Configuration
- IRQ_CTRL_SYNC_EN defined:
  - Each src_i passes through a two-flop synchronizer, reset to 0, before edge capture.
  - Adds 2 cycles: src_i to irq_o latency becomes 4 edges.
- Undefined: src_i feeds edge capture directly; all sources must be clk_i-synchronous.

## Structure
- Package irq_ctrl_pkg contains:
  - Register index constants: REG_PENDING=0, REG_ENABLE=1, REG_CLAIM=2, REG_STATUS=3.
  - State enum: IDLE=0, ASSERT=1, IN_SERVICE=2.
  - Constants: CLAIM_VALID_BIT=31, ID_W=5.
- Sub-module irq_src_edge: per-source optional synchronizer plus prev flop, outputs a one-cycle edge pulse; instantiated NUM_SRC times.
- Priority encoder and FSM live in irq_ctrl.

## Test plan
- Enable = 0x1; src_i[0] rises and stays high -> PENDING reads 0x1, irq_o high 2 cycles after the rise, no re-trigger while held high.
- Enable = 0xF; src_i[3] and src_i[1] rise in the same cycle -> CLAIM read returns 0x8000_0001; PENDING reads 0x8; irq_o low next cycle.
- Continue: complete with id 3 -> ignored, STATUS still IN_SERVICE. Complete with id 1 -> IDLE, then irq_o re-asserts; next CLAIM returns 0x8000_0003.
- Write PENDING 0x4 in the same cycle src_i[2] rises -> pending[2] remains 1.
- Enable = 0; pending = 0x2; CLAIM read -> returns 0x0, state stays IDLE, irq_o stays 0.
- rst_ni low during IN_SERVICE with src_i[0] held high -> after release, pending reads 0x1, enable 0, irq_o 0 until enable written.
